// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner: per-frame input snapshot, BCD decode,
// anti-ghost blanking, leading-zero suppression, decimal points and per-digit blinking.
module seg_scan #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 500,
  parameter int BLINK_HZ       = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits,
  input  logic        blank_lz,
  input  logic [5:0]  dp_mask,
  input  logic [5:0]  blink_mask,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame
);

  localparam int SLOT    = CLK_HZ / SCAN_HZ;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;

  function automatic logic [6:0] bcd_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] lit);
    return SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  function automatic logic [5:0] sel_pol(input logic [5:0] on);
    return SEL_ACTIVE_LOW ? ~on : on;
  endfunction

  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic               load_q, load_d;
  logic [23:0]        dig_q, dig_d;
  logic               lz_en_q, lz_en_d;
  logic [5:0]         dp_q, dp_d;
  logic [5:0]         blk_q, blk_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic               frame_q, frame_d;
  logic [7:0]         seg_q, seg_d;
  logic [5:0]         sel_q, sel_d;

  logic       slot_wrap, snap;
  logic [5:0] lead;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_blk, cur_lz;
  logic [7:0] lit;

  // lead[i]: digit i and every digit above it are zero
  always_comb begin
    lead    = '0;
    lead[5] = (dig_q[23:20] == 4'd0);
    for (int i = 4; i >= 0; i--) begin
      lead[i] = lead[i+1] && (dig_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib = dig_q[4*i +: 4];
        cur_dp  = dp_q[i];
        cur_blk = blk_q[i];
        cur_lz  = (i != 0) && lz_en_q && lead[i];
      end
    end
  end

  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_W'(SLOT - 1));
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    // Snapshot at frame boundary, or on the very first cycle out of reset
    snap    = load_q || (slot_wrap && (idx_q == 3'd5));
    load_d  = 1'b0;
    frame_d = snap;
    dig_d   = snap ? digits     : dig_q;
    lz_en_d = snap ? blank_lz   : lz_en_q;
    dp_d    = snap ? dp_mask    : dp_q;
    blk_d   = snap ? blink_mask : blk_q;

    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BLINK_W'(HALF - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end

    // Blink-off wins over everything, including dp; leading-zero blank keeps dp
    lit = 8'h00;
    if (!(blink_ph_q && cur_blk)) begin
      lit[7]   = cur_dp;
      lit[6:0] = cur_lz ? 7'h00 : bcd_decode(cur_nib);
    end

    if (slot_cnt_q < SLOT_W'(BLANK_CYC)) begin
      seg_d = seg_pol(8'h00);
      sel_d = sel_pol(6'h00);
    end else begin
      seg_d = seg_pol(lit);
      sel_d = sel_pol(6'b000001 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      idx_q       <= 3'd0;
      load_q      <= 1'b1;
      dig_q       <= '0;
      lz_en_q     <= 1'b0;
      dp_q        <= '0;
      blk_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= seg_pol(8'h00);
      sel_q       <= sel_pol(6'h00);
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      idx_q       <= idx_d;
      load_q      <= load_d;
      dig_q       <= dig_d;
      lz_en_q     <= lz_en_d;
      dp_q        <= dp_d;
      blk_q       <= blk_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign seg   = seg_q;
  assign sel   = sel_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SLOT=10, BLANK_CYC=2, blink half-period 50 cycles.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] digits = '0;
  logic        blank_lz = 1'b0;
  logic [5:0]  dp_mask = '0;
  logic [5:0]  blink_mask = '0;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame;

  int total = 0;
  int bad   = 0;
  int pc;

  localparam logic [5:0] SELX [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  seg_scan #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .BLINK_HZ(10),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .blink_mask(blink_mask),
    .seg(seg), .sel(sel), .frame(frame)
  );

  always #5 clk = ~clk;

  // pc = number of clock edges since reset was last sampled high
  always @(posedge clk) begin
    if (rst) pc <= 0;
    else     pc <= pc + 1;
  end

  task automatic at(input int p);
    int n = 0;
    while (pc != p && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (pc != p) begin
      total++; bad++;
      $display("FAIL wait_pc got=%0d want=%0d", pc, p);
    end
  endtask

  task automatic next_b(output int b);
    b = (pc / 60 + 1) * 60;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (seg !== 8'hFF || sel !== 6'h3F || frame !== 1'b0) begin
      bad++; $display("FAIL reset_hold seg=%h sel=%h frame=%b want FF 3F 0", seg, sel, frame);
    end
    rst = 1'b0;
    at(1);
    total++;
    if (frame !== 1'b1) begin bad++; $display("FAIL reset_first_frame got=%b want=1", frame); end
    at(2);
    total++;
    if (sel !== 6'h3F || frame !== 1'b0) begin
      bad++; $display("FAIL reset_blank2 sel=%h frame=%b want 3F 0", sel, frame);
    end
    at(3);
    total++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      bad++; $display("FAIL reset_first_digit sel=%h seg=%h want 3E C0", sel, seg);
    end
    at(12);
    total++;
    if (sel !== 6'h3F) begin bad++; $display("FAIL slot1_blank sel=%h want 3F", sel); end
    at(13);
    total++;
    if (sel !== 6'h3D) begin bad++; $display("FAIL slot1_sel sel=%h want 3D", sel); end
    at(59);
    total++;
    if (frame !== 1'b0) begin bad++; $display("FAIL frame_59 got=%b want=0", frame); end
    at(60);
    total++;
    if (frame !== 1'b1) begin bad++; $display("FAIL frame_60 got=%b want=1", frame); end
    at(61);
    total++;
    if (frame !== 1'b0) begin bad++; $display("FAIL frame_61 got=%b want=0", frame); end
  endtask

  task automatic test_decode;
    logic [7:0] exp [6];
    int b;
    exp = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    digits = 24'h123456;
    next_b(b);
    for (int i = 0; i < 6; i++) begin
      at(b + 10*i + 1);
      total++;
      if (seg !== 8'hFF || sel !== 6'h3F) begin
        bad++; $display("FAIL decode_blank d%0d seg=%h sel=%h want FF 3F", i, seg, sel);
      end
      at(b + 10*i + 3);
      total++;
      if (seg !== exp[i] || sel !== SELX[i]) begin
        bad++; $display("FAIL decode d%0d seg=%h sel=%h want %h %h", i, seg, sel, exp[i], SELX[i]);
      end
    end
  endtask

  task automatic test_dash;
    logic [7:0] exp [6];
    int b;
    exp = '{8'hBF, 8'hC0, 8'h90, 8'hBF, 8'h80, 8'hF8};
    digits = 24'h78C90F;
    next_b(b);
    for (int i = 0; i < 6; i++) begin
      at(b + 10*i + 5);
      total++;
      if (seg !== exp[i] || sel !== SELX[i]) begin
        bad++; $display("FAIL dash d%0d seg=%h sel=%h want %h %h", i, seg, sel, exp[i], SELX[i]);
      end
    end
  endtask

  task automatic test_lz;
    logic [7:0] exp1 [6];
    logic [7:0] exp2 [6];
    int b;
    exp1 = '{8'h92, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF};
    exp2 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    digits = 24'h000105; blank_lz = 1'b1;
    next_b(b);
    for (int i = 0; i < 6; i++) begin
      at(b + 10*i + 4);
      total++;
      if (seg !== exp1[i] || sel !== SELX[i]) begin
        bad++; $display("FAIL lz_105 d%0d seg=%h sel=%h want %h %h", i, seg, sel, exp1[i], SELX[i]);
      end
    end
    digits = 24'h000000; dp_mask = 6'b100000;
    next_b(b);
    for (int i = 0; i < 6; i++) begin
      at(b + 10*i + 4);
      total++;
      if (seg !== exp2[i] || sel !== SELX[i]) begin
        bad++; $display("FAIL lz_zero d%0d seg=%h sel=%h want %h %h", i, seg, sel, exp2[i], SELX[i]);
      end
    end
    blank_lz = 1'b0; dp_mask = '0;
  endtask

  task automatic test_snapshot;
    int b;
    digits = 24'h000009;
    next_b(b);
    at(b + 3);
    total++;
    if (seg !== 8'h90) begin bad++; $display("FAIL snap_old_d0 seg=%h want 90", seg); end
    at(b + 5);
    digits = 24'h000010;
    at(b + 13);
    total++;
    if (seg !== 8'hC0) begin bad++; $display("FAIL snap_hold_d1 seg=%h want C0", seg); end
    at(b + 25);
    total++;
    if (seg !== 8'hC0 || sel !== 6'h3B) begin
      bad++; $display("FAIL snap_hold_d2 seg=%h sel=%h want C0 3B", seg, sel);
    end
    at(b + 60);
    total++;
    if (frame !== 1'b1) begin bad++; $display("FAIL snap_frame got=%b want=1", frame); end
    at(b + 63);
    total++;
    if (seg !== 8'hC0) begin bad++; $display("FAIL snap_new_d0 seg=%h want C0", seg); end
    at(b + 73);
    total++;
    if (seg !== 8'hF9) begin bad++; $display("FAIL snap_new_d1 seg=%h want F9", seg); end
  endtask

  task automatic test_dp_blink;
    int b, p, ph;
    logic [7:0] e;
    digits = 24'h235959; dp_mask = 6'b010100; blink_mask = 6'b000011;
    next_b(b);
    for (int k = 0; k < 5; k++) begin
      p = b + 60*k + 3;
      at(p);
      ph = ((p - 1) / 50) % 2;
      e = (ph == 1) ? 8'hFF : 8'h90;
      total++;
      if (seg !== e || sel !== 6'h3E) begin
        bad++; $display("FAIL blink_d0 pc=%0d seg=%h sel=%h want %h 3E", p, seg, sel, e);
      end
      p = b + 60*k + 13;
      at(p);
      ph = ((p - 1) / 50) % 2;
      e = (ph == 1) ? 8'hFF : 8'h92;
      total++;
      if (seg !== e || sel !== 6'h3D) begin
        bad++; $display("FAIL blink_d1 pc=%0d seg=%h sel=%h want %h 3D", p, seg, sel, e);
      end
      if (k == 0) begin
        at(b + 23);
        total++;
        if (seg !== 8'h10) begin bad++; $display("FAIL dp_d2 seg=%h want 10", seg); end
        at(b + 33);
        total++;
        if (seg !== 8'h92) begin bad++; $display("FAIL nodp_d3 seg=%h want 92", seg); end
        at(b + 43);
        total++;
        if (seg !== 8'h30) begin bad++; $display("FAIL dp_d4 seg=%h want 30", seg); end
        at(b + 53);
        total++;
        if (seg !== 8'hA4) begin bad++; $display("FAIL nodp_d5 seg=%h want A4", seg); end
      end
    end
    dp_mask = '0; blink_mask = '0;
  endtask

  task automatic test_reset_mid;
    int b;
    digits = 24'h00C000;
    next_b(b);
    at(b + 35);
    total++;
    if (seg !== 8'hBF || sel !== 6'h37) begin
      bad++; $display("FAIL dash_d3 seg=%h sel=%h want BF 37", seg, sel);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (seg !== 8'hFF || sel !== 6'h3F || frame !== 1'b0) begin
      bad++; $display("FAIL mid_reset seg=%h sel=%h frame=%b want FF 3F 0", seg, sel, frame);
    end
    rst = 1'b0;
    at(1);
    total++;
    if (frame !== 1'b1) begin bad++; $display("FAIL mid_reset_frame got=%b want=1", frame); end
    at(2);
    total++;
    if (sel !== 6'h3F) begin bad++; $display("FAIL mid_reset_blank sel=%h want 3F", sel); end
    at(3);
    total++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      bad++; $display("FAIL mid_reset_restart sel=%h seg=%h want 3E C0", sel, seg);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_decode;
    test_dash;
    test_lz;
    test_snapshot;
    test_dp_blink;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
